// File: rtl/lcd_spi_tx.sv
// lcd_spi_tx: byte-level SPI (mode 0, MSB first) transmitter for the LCD panel,
// plus sequencing of the panel hardware-reset pin.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   spi_start         transfer request (level, sampled only in IDLE)
//   spi_data[7:0]     byte to send, latched on accept
//   spi_cmd[1:0]      00 command byte, 10/11 data byte, 01 panel reset
//   spi_ready         one-cycle completion pulse
//   busy              high from accept through the spi_ready cycle
//   lcd_sclk/mosi/cs_n/dc/rst_n  LCD panel pins, all registered
module lcd_spi_tx #(
    parameter int unsigned CLK_DIV         = 2,
    parameter int unsigned RST_LO_CYCLES   = 16,
    parameter int unsigned RST_WAIT_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_start,
    input  logic [7:0] spi_data,
    input  logic [1:0] spi_cmd,
    output logic       spi_ready,
    output logic       busy,
    output logic       lcd_sclk,
    output logic       lcd_mosi,
    output logic       lcd_cs_n,
    output logic       lcd_dc,
    output logic       lcd_rst_n
);

    localparam int unsigned CNT_W = 24;
    localparam logic [CNT_W-1:0] DIV_M1    = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] RST_LO_M1 = CNT_W'(RST_LO_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_WT_M1 = CNT_W'(RST_WAIT_CYCLES - 1);
    localparam logic [1:0]       CMD_RST   = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        HOLD,
        RST_LO,
        RST_WAIT,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic             dc_q, dc_d;
    logic             rst_n_q, rst_n_d;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            dc_q    <= 1'b0;
            rst_n_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            dc_q    <= dc_d;
            rst_n_q <= rst_n_d;
        end
    end

    // Next-state and next-output logic; every phase counter loads N-1 and ends at 0
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ready_d = 1'b0;
        busy_d  = busy_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        dc_d    = dc_q;
        rst_n_d = rst_n_q;

        unique case (state_q)
            IDLE: begin
                if (spi_start) begin
                    busy_d = 1'b1;
                    if (spi_cmd == CMD_RST) begin
                        rst_n_d = 1'b0;
                        cnt_d   = RST_LO_M1;
                        state_d = RST_LO;
                    end else begin
                        shift_d = spi_data;
                        dc_d    = (spi_cmd != 2'b00);
                        cs_n_d  = 1'b0;
                        mosi_d  = spi_data[7];
                        bit_d   = '0;
                        cnt_d   = DIV_M1;
                        state_d = SHIFT_LO;
                    end
                end
            end
            SHIFT_LO: begin
                if (cnt_q == '0) begin
                    sclk_d  = 1'b1;
                    cnt_d   = DIV_M1;
                    state_d = SHIFT_HI;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SHIFT_HI: begin
                if (cnt_q == '0) begin
                    sclk_d = 1'b0;
                    cnt_d  = DIV_M1;
                    if (bit_q == 3'd7) begin
                        state_d = HOLD;
                    end else begin
                        // Next bit appears on MOSI together with the falling edge
                        shift_d = {shift_q[6:0], 1'b0};
                        mosi_d  = shift_q[6];
                        bit_d   = bit_q + 1'b1;
                        state_d = SHIFT_LO;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    cs_n_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RST_LO: begin
                if (cnt_q == '0) begin
                    rst_n_d = 1'b1;
                    cnt_d   = RST_WT_M1;
                    state_d = RST_WAIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RST_WAIT: begin
                if (cnt_q == '0) begin
                    ready_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign spi_ready = ready_q;
    assign busy      = busy_q;
    assign lcd_sclk  = sclk_q;
    assign lcd_mosi  = mosi_q;
    assign lcd_cs_n  = cs_n_q;
    assign lcd_dc    = dc_q;
    assign lcd_rst_n = rst_n_q;

endmodule

// File: tb/tb_lcd_spi_tx.sv
// tb_lcd_spi_tx: directed and randomized checks of lcd_spi_tx against a
// cycle-numbered model of the panel-side waveform.
module tb_lcd_spi_tx;

    localparam int D      = 2;
    localparam int RLO    = 16;
    localparam int RWT    = 32;
    localparam int T      = 17 * D;
    localparam int M_SINGLE = 0;
    localparam int M_CHURN  = 1;
    localparam int M_HS     = 2;
    localparam int M_RST    = 3;

    logic       clk;
    logic       reset;
    logic       spi_start;
    logic [7:0] spi_data;
    logic [1:0] spi_cmd;
    logic       spi_ready;
    logic       busy;
    logic       lcd_sclk;
    logic       lcd_mosi;
    logic       lcd_cs_n;
    logic       lcd_dc;
    logic       lcd_rst_n;

    int n_assert;
    int n_fail;
    int hs_idx;
    int hs_gap;

    // Per-cycle samples; index n is cycle n relative to the accept cycle 0
    logic sclk_q[$];
    logic mosi_q[$];
    logic cs_q[$];
    logic dc_q[$];
    logic rdy_q[$];
    logic busy_q[$];
    logic rst_q[$];

    lcd_spi_tx #(
        .CLK_DIV        (D),
        .RST_LO_CYCLES  (RLO),
        .RST_WAIT_CYCLES(RWT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .spi_start(spi_start),
        .spi_data (spi_data),
        .spi_cmd  (spi_cmd),
        .spi_ready(spi_ready),
        .busy     (busy),
        .lcd_sclk (lcd_sclk),
        .lcd_mosi (lcd_mosi),
        .lcd_cs_n (lcd_cs_n),
        .lcd_dc   (lcd_dc),
        .lcd_rst_n(lcd_rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        sclk_q.push_back(lcd_sclk);
        mosi_q.push_back(lcd_mosi);
        cs_q.push_back(lcd_cs_n);
        dc_q.push_back(lcd_dc);
        rdy_q.push_back(spi_ready);
        busy_q.push_back(busy);
        rst_q.push_back(lcd_rst_n);
    endtask

    // Called at a negedge with the request already driven (cycle 0)
    task automatic run(input int ncyc, input int mode);
        sclk_q.delete(); mosi_q.delete(); cs_q.delete(); dc_q.delete();
        rdy_q.delete(); busy_q.delete(); rst_q.delete();
        sample();
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge clk);
            #1;
            if (mode == M_SINGLE || mode == M_CHURN || mode == M_RST)
                spi_start = 1'b0;
            if (mode == M_CHURN) begin
                spi_data = 8'($urandom);
                spi_cmd  = 2'($urandom);
            end
            if (mode == M_RST) reset = (n == 10);
            if (mode == M_HS) begin
                if (rdy_q[rdy_q.size()-1]) begin
                    hs_idx++;
                    spi_start = 1'b0;
                    hs_gap = $urandom_range(0, 2);
                end
                if (!spi_start && hs_idx < 8) begin
                    if (hs_gap == 0) begin
                        spi_start = 1'b1;
                        spi_data  = 8'(hs_idx);
                        spi_cmd   = 2'b10;
                    end else begin
                        hs_gap--;
                    end
                end
            end
            @(negedge clk);
            sample();
        end
    endtask

    task automatic check_byte(input string tag, input logic [7:0] exp_b, input logic exp_dc);
        int rises = 0, rise_bad = 0, hi_bad = 0, rdy_n = 0, rdy_c = -1;
        int cs_lo = 0, cs_first = -1, cs_last = -1, dc_bad = 0;
        logic [7:0] got = 8'h00;
        logic cur = 1'b0;
        for (int c = 1; c < sclk_q.size(); c++) begin
            if (sclk_q[c] && !sclk_q[c-1]) begin
                if (rises < 8 && c != 1 + D + 2 * D * rises) rise_bad++;
                got = {got[6:0], mosi_q[c]};
                cur = mosi_q[c];
                rises++;
            end else if (sclk_q[c] && mosi_q[c] !== cur) begin
                hi_bad++;
            end
            if (rdy_q[c]) begin rdy_n++; rdy_c = c; end
            if (!cs_q[c]) begin
                cs_lo++;
                if (cs_first < 0) cs_first = c;
                cs_last = c;
                if (dc_q[c] !== exp_dc) dc_bad++;
            end
        end
        chk({tag, ".rises"},     rises, 8);
        chk({tag, ".rise_time"}, rise_bad, 0);
        chk({tag, ".mosi_hold"}, hi_bad, 0);
        chk({tag, ".byte"},      got, exp_b);
        chk({tag, ".rdy_cnt"},   rdy_n, 1);
        chk({tag, ".rdy_cycle"}, rdy_c, T + 1);
        chk({tag, ".cs_at_rdy"}, cs_q[T+1], 1);
        chk({tag, ".cs_low_n"},  cs_lo, T);
        chk({tag, ".cs_first"},  cs_first, 1);
        chk({tag, ".cs_last"},   cs_last, T);
        chk({tag, ".dc"},        dc_bad, 0);
        chk({tag, ".busy_rdy"},  busy_q[T+1], 1);
        chk({tag, ".busy_end"},  busy_q[T+2], 0);
        chk({tag, ".dc_hold"},   dc_q[T+3], exp_dc);
    endtask

    task automatic send(input string tag, input logic [7:0] b, input logic [1:0] cmd, input int mode);
        @(negedge clk);
        spi_start = 1'b1;
        spi_data  = b;
        spi_cmd   = cmd;
        run(T + 4, mode);
        check_byte(tag, b, cmd != 2'b00);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset     = 1'b1;
        spi_start = 1'b0;
        spi_data  = 8'h00;
        spi_cmd   = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.sclk",  lcd_sclk,  0);
        chk("rst.mosi",  lcd_mosi,  0);
        chk("rst.cs_n",  lcd_cs_n,  1);
        chk("rst.dc",    lcd_dc,    0);
        chk("rst.rst_n", lcd_rst_n, 1);
        chk("rst.ready", spi_ready, 0);
        chk("rst.busy",  busy,      0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        send("data_a5", 8'hA5, 2'b10, M_SINGLE);
        send("cmd_2c",  8'h2C, 2'b00, M_SINGLE);

        // Panel hardware reset
        begin
            int lo_n = 0, lo_first = -1, lo_last = -1, rdy_n = 0, rdy_c = -1, cs_lo = 0, sck_hi = 0;
            @(negedge clk);
            spi_start = 1'b1;
            spi_cmd   = 2'b01;
            run(RLO + RWT + 4, M_SINGLE);
            for (int c = 1; c < rst_q.size(); c++) begin
                if (!rst_q[c]) begin
                    lo_n++;
                    if (lo_first < 0) lo_first = c;
                    lo_last = c;
                end
                if (rdy_q[c]) begin rdy_n++; rdy_c = c; end
                if (!cs_q[c]) cs_lo++;
                if (sclk_q[c]) sck_hi++;
            end
            chk("prst.low_n",     lo_n, RLO);
            chk("prst.low_first", lo_first, 1);
            chk("prst.low_last",  lo_last, RLO);
            chk("prst.rdy_cnt",   rdy_n, 1);
            chk("prst.rdy_cycle", rdy_c, 1 + RLO + RWT);
            chk("prst.cs_low",    cs_lo, 0);
            chk("prst.sclk_hi",   sck_hi, 0);
            chk("prst.dc_kept",   dc_q[RLO], 0);
        end

        // Randomized bytes and transfer types
        for (int i = 0; i < 5; i++) begin
            logic [7:0] b;
            logic [1:0] cmd;
            int r;
            b = 8'($urandom);
            r = $urandom_range(0, 2);
            cmd = (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : 2'b11;
            send($sformatf("rand%0d", i), b, cmd, M_SINGLE);
        end

        // Inputs churn every cycle after accept
        send("churn_3c", 8'h3C, 2'b00, M_CHURN);
        send("churn_rnd", 8'($urandom), 2'b11, M_CHURN);

        // Drawing-FSM style handshake, bytes 0..7
        begin
            int acc_n = 0, rx_n = 0, rdy_n = 0, last_rdy = -100, order_bad = 0, gap_bad = 0, nbits = 0;
            logic [7:0] sh = 8'h00;
            @(negedge clk);
            hs_idx = 0;
            hs_gap = 0;
            spi_start = 1'b1;
            spi_data  = 8'h00;
            spi_cmd   = 2'b10;
            run(8 * (T + 5) + 10, M_HS);
            spi_start = 1'b0;
            for (int c = 1; c < cs_q.size(); c++) begin
                if (!cs_q[c] && cs_q[c-1]) begin
                    if (c - 1 < last_rdy + 1) gap_bad++;
                    nbits = 0;
                    acc_n++;
                end
                if (sclk_q[c] && !sclk_q[c-1]) begin
                    sh = {sh[6:0], mosi_q[c]};
                    nbits++;
                    if (nbits == 8) begin
                        if (sh !== 8'(rx_n)) order_bad++;
                        rx_n++;
                    end
                end
                if (rdy_q[c]) begin rdy_n++; last_rdy = c; end
            end
            chk("hs.accepts", acc_n, 8);
            chk("hs.bytes",   rx_n, 8);
            chk("hs.readys",  rdy_n, 8);
            chk("hs.order",   order_bad, 0);
            chk("hs.gap",     gap_bad, 0);
        end

        // Reset in cycle 10 of a 0xFF transfer
        begin
            int rdy_n = 0;
            @(negedge clk);
            spi_start = 1'b1;
            spi_data  = 8'hFF;
            spi_cmd   = 2'b10;
            run(T + 4, M_RST);
            reset = 1'b0;
            for (int c = 1; c < rdy_q.size(); c++) if (rdy_q[c]) rdy_n++;
            chk("mrst.cs_c10",   cs_q[10], 0);
            chk("mrst.busy_c10", busy_q[10], 1);
            chk("mrst.cs_n",     cs_q[11], 1);
            chk("mrst.sclk",     sclk_q[11], 0);
            chk("mrst.busy",     busy_q[11], 0);
            chk("mrst.mosi",     mosi_q[11], 0);
            chk("mrst.dc",       dc_q[11], 0);
            chk("mrst.no_rdy",   rdy_n, 0);
        end
        send("after_81", 8'h81, 2'b10, M_SINGLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
